leaderboard_ctrl: RTL and testbench

//  Keeps a sorted top-DEPTH score table for Doodle Fall; scores[0] is the highest.

---
 rtl/leaderboard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_leaderboard_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaderboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : leaderboard_ctrl
//  Brief    : Sorted top-DEPTH score table for Doodle Fall. Accepts one final
//             score per game over valid/ready, inserts it with a multi-cycle
//             scan/shift FSM, and exposes a combinational read port plus the
//             current best score for the display.
//  Revision : 1.0  initial release
// ============================================================================
module leaderboard_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [WIDTH-1:0]             req_score,
    output logic                         req_ready,
    input  logic                         clr,
    output logic                         done,
    output logic                         placed,
    output logic [$clog2(DEPTH+1)-1:0]   rank,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [WIDTH-1:0]             rd_data,
    output logic [WIDTH-1:0]             best
);

    // Index width into the table, and rank width (rank can be DEPTH = "not placed")
    localparam int c_iw = $clog2(DEPTH);
    localparam int c_rw = $clog2(DEPTH + 1);

    localparam logic [c_iw-1:0] c_last      = c_iw'(DEPTH - 1);
    localparam logic [c_rw-1:0] c_rank_none = c_rw'(DEPTH);

    // FSM encoding
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_scan  = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_clear = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]        r_state;
    logic [WIDTH-1:0]  r_scores [DEPTH];
    logic [c_iw-1:0]   r_idx;        // scan position
    logic [c_iw-1:0]   r_ptr;        // shift / clear write position
    logic [WIDTH-1:0]  r_score_q;    // score latched at accept
    logic [c_rw-1:0]   r_rank_q;     // slot chosen by the scan
    logic              r_done;
    logic              r_placed;
    logic [c_rw-1:0]   r_rank;

    logic [c_rw-1:0]   w_idx_ext;
    logic [c_rw-1:0]   w_ptr_ext;
    logic              w_beats;

    assign w_idx_ext = c_rw'(r_idx);
    assign w_ptr_ext = c_rw'(r_ptr);

    // Strictly greater: a tie ranks below the existing entry, and a zero score
    // can never displace a zero entry.
    assign w_beats   = (r_score_q > r_scores[r_idx]);

    // clr has priority over a same-cycle request, so ready drops while it is high
    assign req_ready = (r_state == c_st_idle) && !clr;

    assign done      = r_done;
    assign placed    = r_placed;
    assign rank      = r_rank;
    assign best      = r_scores[0];

    // Read port: when DEPTH is not a power of two the index can exceed the table
    generate
        if (DEPTH == (1 << c_iw)) begin : g_rd_full
            assign rd_data = r_scores[rd_idx];
        end else begin : g_rd_guarded
            assign rd_data = (int'(rd_idx) < DEPTH) ? r_scores[rd_idx] : '0;
        end
    endgenerate

    // Insert / clear sequencer with the score table and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_scores  <= '{default: '0};
            r_idx     <= '0;
            r_ptr     <= '0;
            r_score_q <= '0;
            r_rank_q  <= c_rank_none;
            r_done    <= 1'b0;
            r_placed  <= 1'b0;
            r_rank    <= c_rank_none;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (clr) begin
                        r_ptr   <= '0;
                        r_state <= c_st_clear;
                    end else if (req_valid) begin
                        r_score_q <= req_score;
                        r_idx     <= '0;
                        r_state   <= c_st_scan;
                    end
                end

                c_st_scan: begin
                    if (w_beats) begin
                        // Found the slot; make room by shifting from the bottom up
                        r_rank_q <= w_idx_ext;
                        r_ptr    <= c_last;
                        r_state  <= c_st_shift;
                    end else if (r_idx == c_last) begin
                        r_rank_q <= c_rank_none;
                        r_placed <= 1'b0;
                        r_rank   <= c_rank_none;
                        r_done   <= 1'b1;
                        r_state  <= c_st_done;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                c_st_shift: begin
                    if (w_ptr_ext != r_rank_q) begin
                        // ptr > rank_q >= 0 here, so ptr-1 is always a valid slot;
                        // the old bottom entry is overwritten on the first move
                        r_scores[r_ptr] <= r_scores[r_ptr - 1'b1];
                        r_ptr           <= r_ptr - 1'b1;
                    end else begin
                        r_scores[r_ptr] <= r_score_q;
                        r_placed        <= 1'b1;
                        r_rank          <= r_rank_q;
                        r_done          <= 1'b1;
                        r_state         <= c_st_done;
                    end
                end

                c_st_clear: begin
                    r_scores[r_ptr] <= '0;
                    if (r_ptr == c_last) begin
                        r_rank_q <= c_rank_none;
                        r_placed <= 1'b0;
                        r_rank   <= c_rank_none;
                        r_done   <= 1'b1;
                        r_state  <= c_st_done;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end

                c_st_done: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leaderboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leaderboard_ctrl
//  Brief    : Directed self-checking bench for leaderboard_ctrl (DEPTH=4,
//             WIDTH=32) with hand-computed expected tables and latencies.
//  Revision : 1.0  initial release
// ============================================================================
module tb_leaderboard_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic [WIDTH-1:0]  req_score;
    logic              req_ready;
    logic              clr;
    logic              done;
    logic              placed;
    logic [2:0]        rank;
    logic [1:0]        rd_idx;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  best;

    logic [WIDTH-1:0]  tbl [DEPTH];

    int errors = 0;
    int checks = 0;

    leaderboard_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_score (req_score),
        .req_ready (req_ready),
        .clr       (clr),
        .done      (done),
        .placed    (placed),
        .rank      (rank),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .best      (best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot the table through the read port (fits within half a clock)
    task automatic read_table();
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = 2'(i);
            #1;
            tbl[i] = rd_data;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One request (insert and/or clear); returns cycles from accept edge to done, -1 on timeout
    task automatic run_op(input logic [WIDTH-1:0] s, input bit do_clr, input bit do_req,
                          output int cycles);
        @(negedge clk);
        req_valid = do_req;
        req_score = s;
        clr       = do_clr;
        @(posedge clk);
        cycles = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            clr       = 1'b0;
            if (done === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic load_table();
        int c;
        do_reset();
        run_op(32'd20, 1'b0, 1'b1, c);
        run_op(32'd30, 1'b0, 1'b1, c);
        run_op(32'd40, 1'b0, 1'b1, c);
        run_op(32'd50, 1'b0, 1'b1, c);
    endtask

    task automatic test_reset();
        int done_seen;
        rst = 1'b1;
        req_valid = 1'b0;
        req_score = '0;
        clr = 1'b0;
        rd_idx = '0;
        @(negedge clk);
        checks++;
        if (best !== 32'd0 || rank !== 3'd4 || done !== 1'b0 || placed !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: best=%0d rank=%0d done=%b placed=%b, want 0/4/0/0",
                     best, rank, done, placed);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
        end

        // Abort an insert of 60 into {50,40,30,20} in the middle of SHIFT
        load_table();
        @(negedge clk);
        req_valid = 1'b1;
        req_score = 32'd60;
        @(posedge clk);
        @(negedge clk);            // cycle 1: SCAN
        req_valid = 1'b0;
        @(negedge clk);            // cycle 2: SHIFT
        @(negedge clk);            // cycle 3: SHIFT, table partly shifted
        rst = 1'b1;
        #1;
        checks++;
        if (best !== 32'd0) begin
            errors++;
            $display("FAIL reset_async_best: best=%0d, want 0", best);
        end
        read_table();
        checks++;
        if (tbl[0] !== 0 || tbl[1] !== 0 || tbl[2] !== 0 || tbl[3] !== 0) begin
            errors++;
            $display("FAIL reset_mid_shift_table: got {%0d,%0d,%0d,%0d}, want {0,0,0,0}",
                     tbl[0], tbl[1], tbl[2], tbl[3]);
        end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_done: done pulses=%0d req_ready=%b, want 0 and 1",
                     done_seen, req_ready);
        end
    endtask

    task automatic test_insert_empty();
        int c;
        do_reset();
        run_op(32'd100, 1'b0, 1'b1, c);
        checks++;
        if (c != 6 || placed !== 1'b1 || rank !== 3'd0) begin
            errors++;
            $display("FAIL insert_empty: cycles=%0d placed=%b rank=%0d, want 6/1/0", c, placed, rank);
        end
        read_table();
        checks++;
        if (tbl[0] !== 100 || tbl[1] !== 0 || tbl[2] !== 0 || tbl[3] !== 0 || best !== 100) begin
            errors++;
            $display("FAIL insert_empty_table: got {%0d,%0d,%0d,%0d} best=%0d, want {100,0,0,0} 100",
                     tbl[0], tbl[1], tbl[2], tbl[3], best);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || placed !== 1'b1 || rank !== 3'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL insert_empty_hold: done=%b placed=%b rank=%0d ready=%b, want 0/1/0/1",
                     done, placed, rank, req_ready);
        end
    endtask

    task automatic test_insert_mid();
        int c;
        load_table();
        read_table();
        checks++;
        if (tbl[0] !== 50 || tbl[1] !== 40 || tbl[2] !== 30 || tbl[3] !== 20) begin
            errors++;
            $display("FAIL load_table: got {%0d,%0d,%0d,%0d}, want {50,40,30,20}",
                     tbl[0], tbl[1], tbl[2], tbl[3]);
        end
        run_op(32'd35, 1'b0, 1'b1, c);
        checks++;
        if (c != 6 || placed !== 1'b1 || rank !== 3'd2) begin
            errors++;
            $display("FAIL insert_mid: cycles=%0d placed=%b rank=%0d, want 6/1/2", c, placed, rank);
        end
        read_table();
        checks++;
        if (tbl[0] !== 50 || tbl[1] !== 40 || tbl[2] !== 35 || tbl[3] !== 30) begin
            errors++;
            $display("FAIL insert_mid_table: got {%0d,%0d,%0d,%0d}, want {50,40,35,30}",
                     tbl[0], tbl[1], tbl[2], tbl[3]);
        end
    endtask

    task automatic test_not_placed_and_tie();
        int c;
        load_table();
        run_op(32'd10, 1'b0, 1'b1, c);
        checks++;
        if (c != 5 || placed !== 1'b0 || rank !== 3'd4) begin
            errors++;
            $display("FAIL not_placed: cycles=%0d placed=%b rank=%0d, want 5/0/4", c, placed, rank);
        end
        read_table();
        checks++;
        if (tbl[0] !== 50 || tbl[1] !== 40 || tbl[2] !== 30 || tbl[3] !== 20) begin
            errors++;
            $display("FAIL not_placed_table: got {%0d,%0d,%0d,%0d}, want {50,40,30,20}",
                     tbl[0], tbl[1], tbl[2], tbl[3]);
        end
        run_op(32'd40, 1'b0, 1'b1, c);
        checks++;
        if (c != 6 || placed !== 1'b1 || rank !== 3'd2) begin
            errors++;
            $display("FAIL tie: cycles=%0d placed=%b rank=%0d, want 6/1/2", c, placed, rank);
        end
        read_table();
        checks++;
        if (tbl[0] !== 50 || tbl[1] !== 40 || tbl[2] !== 40 || tbl[3] !== 30) begin
            errors++;
            $display("FAIL tie_table: got {%0d,%0d,%0d,%0d}, want {50,40,40,30}",
                     tbl[0], tbl[1], tbl[2], tbl[3]);
        end
    endtask

    task automatic test_zero_score();
        int c;
        do_reset();
        run_op(32'd0, 1'b0, 1'b1, c);
        checks++;
        if (c != 5 || placed !== 1'b0 || rank !== 3'd4 || best !== 32'd0) begin
            errors++;
            $display("FAIL zero_score: cycles=%0d placed=%b rank=%0d best=%0d, want 5/0/4/0",
                     c, placed, rank, best);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int busy_ready;
        load_table();
        @(negedge clk);
        req_valid = 1'b1;
        req_score = 32'd35;
        @(posedge clk);
        c = -1;
        busy_ready = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (req_ready !== 1'b0) busy_ready++;
            if (done === 1'b1) begin
                c = n;
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (c != 6 || busy_ready != 0) begin
            errors++;
            $display("FAIL hold_valid: cycles=%0d ready_high_while_busy=%0d, want 6 and 0", c, busy_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_valid_idle: req_ready=%b done=%b, want 1/0", req_ready, done);
        end
        read_table();
        checks++;
        if (tbl[0] !== 50 || tbl[1] !== 40 || tbl[2] !== 35 || tbl[3] !== 30) begin
            errors++;
            $display("FAIL hold_valid_table: got {%0d,%0d,%0d,%0d}, want {50,40,35,30}",
                     tbl[0], tbl[1], tbl[2], tbl[3]);
        end
    endtask

    task automatic test_clr_priority();
        int c;
        load_table();
        @(negedge clk);
        clr       = 1'b1;
        req_valid = 1'b1;
        req_score = 32'd999;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: req_ready=%b, want 0", req_ready);
        end
        @(posedge clk);
        c = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            clr       = 1'b0;
            req_valid = 1'b0;
            if (done === 1'b1) begin
                c = n;
                break;
            end
        end
        checks++;
        if (c != 5 || placed !== 1'b0 || rank !== 3'd4) begin
            errors++;
            $display("FAIL clr_done: cycles=%0d placed=%b rank=%0d, want 5/0/4", c, placed, rank);
        end
        read_table();
        checks++;
        if (tbl[0] !== 0 || tbl[1] !== 0 || tbl[2] !== 0 || tbl[3] !== 0 || best !== 0) begin
            errors++;
            $display("FAIL clr_table: got {%0d,%0d,%0d,%0d} best=%0d, want all 0",
                     tbl[0], tbl[1], tbl[2], tbl[3], best);
        end
    endtask

    initial begin
        test_reset();
        test_insert_empty();
        test_insert_mid();
        test_not_placed_and_tie();
        test_zero_score();
        test_back_to_back();
        test_clr_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
